// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stall, branch flush, memory
// freeze with a timeout watchdog, and saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  idRs_i,
  input  logic [2:0]  idRt_i,
  input  logic        idUsesRs_i,
  input  logic        idUsesRt_i,
  input  logic        exMemRead_i,
  input  logic [2:0]  exRt_i,
  input  logic        memBranchTaken_i,
  input  logic        memBusy_i,
  output logic        pcWrite_o,
  output logic        pcSrc_o,
  output logic        ifidWrite_o,
  output logic        ifidFlush_o,
  output logic        idexWrite_o,
  output logic        idexBubble_o,
  output logic        exmemWrite_o,
  output logic        exmemBubble_o,
  output logic        memError_o,
  output logic [1:0]  state_o,
  output logic [15:0] stallCount_o,
  output logic [15:0] flushCount_o
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    FREEZE = 2'b01,
    HALT   = 2'b10
  } state_e;

  // Timer value seen during the last busy cycle before the watchdog fires.
  localparam logic [7:0] BusyLast = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  busy_q, busy_d;
  logic        memError_q, memError_d;
  logic [15:0] stallCount_q, stallCount_d;
  logic [15:0] flushCount_q, flushCount_d;
  logic        hz;

  assign hz = exMemRead_i & (exRt_i != 3'd0) &
              ((idUsesRs_i & (idRs_i == exRt_i)) | (idUsesRt_i & (idRt_i == exRt_i)));

  always_comb begin
    pcWrite_o     = 1'b1;
    pcSrc_o       = 1'b0;
    ifidWrite_o   = 1'b1;
    ifidFlush_o   = 1'b0;
    idexWrite_o   = 1'b1;
    idexBubble_o  = 1'b0;
    exmemWrite_o  = 1'b1;
    exmemBubble_o = 1'b0;
    if (rst_i) begin
      pcWrite_o     = 1'b0;
      ifidWrite_o   = 1'b0;
      idexWrite_o   = 1'b0;
      exmemWrite_o  = 1'b0;
      ifidFlush_o   = 1'b1;
      idexBubble_o  = 1'b1;
      exmemBubble_o = 1'b1;
    end else if (state_q == HALT || memBusy_i) begin
      pcWrite_o    = 1'b0;
      ifidWrite_o  = 1'b0;
      idexWrite_o  = 1'b0;
      exmemWrite_o = 1'b0;
    end else if (memBranchTaken_i) begin
      pcSrc_o       = 1'b1;
      ifidFlush_o   = 1'b1;
      idexBubble_o  = 1'b1;
      exmemBubble_o = 1'b1;
    end else if (hz) begin
      pcWrite_o    = 1'b0;
      ifidWrite_o  = 1'b0;
      idexBubble_o = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    memError_d   = memError_q;
    stallCount_d = stallCount_q;
    flushCount_d = flushCount_q;
    if (state_q != HALT) begin
      if (memBusy_i) begin
        busy_d = busy_q + 8'd1;
        if (busy_q == BusyLast) begin
          state_d    = HALT;
          memError_d = 1'b1;
        end else begin
          state_d = FREEZE;
        end
      end else begin
        busy_d  = 8'd0;
        state_d = RUN;
        if (memBranchTaken_i) begin
          if (flushCount_q != 16'hFFFF) flushCount_d = flushCount_q + 16'd1;
        end else if (hz) begin
          if (stallCount_q != 16'hFFFF) stallCount_d = stallCount_q + 16'd1;
        end
      end
    end else if (!memBusy_i) begin
      busy_d = 8'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      busy_q       <= 8'd0;
      memError_q   <= 1'b0;
      stallCount_q <= 16'd0;
      flushCount_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      memError_q   <= memError_d;
      stallCount_q <= stallCount_d;
      flushCount_q <= flushCount_d;
    end
  end

  assign state_o      = state_q;
  assign memError_o   = memError_q;
  assign stallCount_o = stallCount_q;
  assign flushCount_o = flushCount_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (watchdog set to 4 cycles): the driver queues
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       busy;
    logic       br;
    logic       emr;
    logic [2:0] ert;
    logic       urs;
    logic       urt;
    logic [2:0] rs;
    logic [2:0] rt;
  } in_t;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [1:0]  st;
    logic        err;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  // ctrl order: pcWrite pcSrc ifidWrite ifidFlush idexWrite idexBubble exmemWrite exmemBubble
  localparam logic [7:0] C_NORM = 8'b1010_1010;
  localparam logic [7:0] C_BR   = 8'b1111_1111;
  localparam logic [7:0] C_STL  = 8'b0000_1110;
  localparam logic [7:0] C_FRZ  = 8'b0000_0000;
  localparam logic [7:0] C_RST  = 8'b0001_0101;
  localparam logic [1:0] S_RUN = 2'b00, S_FRZ = 2'b01, S_HLT = 2'b10;

  logic        clk = 1'b0;
  logic        rst, memBusy, memBranchTaken, exMemRead, idUsesRs, idUsesRt;
  logic [2:0]  exRt, idRs, idRt;
  logic        pcWrite, pcSrc, ifidWrite, ifidFlush, idexWrite, idexBubble;
  logic        exmemWrite, exmemBubble, memError;
  logic [1:0]  state;
  logic [15:0] stallCount, flushCount;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .idRs_i(idRs), .idRt_i(idRt), .idUsesRs_i(idUsesRs), .idUsesRt_i(idUsesRt),
    .exMemRead_i(exMemRead), .exRt_i(exRt),
    .memBranchTaken_i(memBranchTaken), .memBusy_i(memBusy),
    .pcWrite_o(pcWrite), .pcSrc_o(pcSrc), .ifidWrite_o(ifidWrite), .ifidFlush_o(ifidFlush),
    .idexWrite_o(idexWrite), .idexBubble_o(idexBubble),
    .exmemWrite_o(exmemWrite), .exmemBubble_o(exmemBubble),
    .memError_o(memError), .state_o(state),
    .stallCount_o(stallCount), .flushCount_o(flushCount)
  );

  function automatic in_t mk(logic r, logic b, logic br, logic emr, logic [2:0] ert,
                             logic urs, logic urt, logic [2:0] rs, logic [2:0] rt);
    mk = '{rst: r, busy: b, br: br, emr: emr, ert: ert, urs: urs, urt: urt, rs: rs, rt: rt};
  endfunction

  function automatic exp_t ex(logic [7:0] c, logic [1:0] s, logic e,
                              logic [15:0] sc, logic [15:0] fc);
    ex = '{ctrl: c, st: s, err: e, stall: sc, flush: fc};
  endfunction

  task automatic drive(input in_t i);
    @(posedge clk);
    #1;
    rst = i.rst; memBusy = i.busy; memBranchTaken = i.br; exMemRead = i.emr;
    exRt = i.ert; idUsesRs = i.urs; idUsesRt = i.urt; idRs = i.rs; idRt = i.rt;
  endtask

  task automatic vec(input in_t i, input exp_t e);
    drive(i);
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [7:0] c;
      e = sb_q.pop_front();
      c = {pcWrite, pcSrc, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemWrite, exmemBubble};
      checks++;
      if (c !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl @%0t: got %b expected %b", $time, c, e.ctrl);
      end
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state @%0t: got %b expected %b", $time, state, e.st);
      end
      checks++;
      if (memError !== e.err) begin
        errors++;
        $display("FAIL memError @%0t: got %b expected %b", $time, memError, e.err);
      end
      checks++;
      if (stallCount !== e.stall) begin
        errors++;
        $display("FAIL stallCount @%0t: got %h expected %h", $time, stallCount, e.stall);
      end
      checks++;
      if (flushCount !== e.flush) begin
        errors++;
        $display("FAIL flushCount @%0t: got %h expected %h", $time, flushCount, e.flush);
      end
    end
  end

  initial begin
    in_t idle, rsti, lu, lu0, lurt, nors, brn, bsy, bsybr, brlu, bsyrst;
    int  wait_cyc;
    idle   = mk(0, 0, 0, 0, 3'd0, 0, 0, 3'd0, 3'd0);
    rsti   = mk(1, 0, 0, 0, 3'd0, 0, 0, 3'd0, 3'd0);
    lu     = mk(0, 0, 0, 1, 3'd3, 1, 0, 3'd3, 3'd0);
    lu0    = mk(0, 0, 0, 1, 3'd0, 1, 0, 3'd0, 3'd0);
    lurt   = mk(0, 0, 0, 1, 3'd5, 0, 1, 3'd5, 3'd5);
    nors   = mk(0, 0, 0, 1, 3'd4, 0, 0, 3'd4, 3'd4);
    brn    = mk(0, 0, 1, 0, 3'd0, 0, 0, 3'd0, 3'd0);
    bsy    = mk(0, 1, 0, 0, 3'd0, 0, 0, 3'd0, 3'd0);
    bsybr  = mk(0, 1, 1, 0, 3'd0, 0, 0, 3'd0, 3'd0);
    brlu   = mk(0, 0, 1, 1, 3'd3, 1, 0, 3'd3, 3'd0);
    bsyrst = mk(1, 1, 0, 0, 3'd0, 0, 0, 3'd0, 3'd0);

    rst = 1'b1; memBusy = 1'b0; memBranchTaken = 1'b0; exMemRead = 1'b0;
    exRt = 3'd0; idUsesRs = 1'b0; idUsesRt = 1'b0; idRs = 3'd0; idRt = 3'd0;
    drive(rsti);
    vec(rsti, ex(C_RST,  S_RUN, 0, 0, 0));
    vec(idle, ex(C_NORM, S_RUN, 0, 0, 0));
    // load-use via rs, then r0 and non-read cases that must not stall
    vec(lu,   ex(C_STL,  S_RUN, 0, 0, 0));
    vec(idle, ex(C_NORM, S_RUN, 0, 1, 0));
    vec(lu0,  ex(C_NORM, S_RUN, 0, 1, 0));
    vec(idle, ex(C_NORM, S_RUN, 0, 1, 0));
    vec(brn,  ex(C_BR,   S_RUN, 0, 1, 0));
    vec(idle, ex(C_NORM, S_RUN, 0, 1, 1));
    vec(brlu, ex(C_BR,   S_RUN, 0, 1, 1));
    vec(idle, ex(C_NORM, S_RUN, 0, 1, 2));
    vec(lurt, ex(C_STL,  S_RUN, 0, 1, 2));
    vec(idle, ex(C_NORM, S_RUN, 0, 2, 2));
    vec(nors, ex(C_NORM, S_RUN, 0, 2, 2));
    // 3-cycle freeze, below the watchdog limit
    vec(bsy,  ex(C_FRZ,  S_RUN, 0, 2, 2));
    vec(bsy,  ex(C_FRZ,  S_FRZ, 0, 2, 2));
    vec(bsy,  ex(C_FRZ,  S_FRZ, 0, 2, 2));
    vec(idle, ex(C_NORM, S_FRZ, 0, 2, 2));
    vec(idle, ex(C_NORM, S_RUN, 0, 2, 2));
    // branch held off by freeze, taken in first unfrozen cycle
    vec(bsybr, ex(C_FRZ, S_RUN, 0, 2, 2));
    vec(bsybr, ex(C_FRZ, S_FRZ, 0, 2, 2));
    vec(brn,  ex(C_BR,   S_FRZ, 0, 2, 2));
    vec(idle, ex(C_NORM, S_RUN, 0, 2, 3));
    // watchdog: 4 busy cycles -> HALT from cycle 5
    vec(bsy,  ex(C_FRZ,  S_RUN, 0, 2, 3));
    vec(bsy,  ex(C_FRZ,  S_FRZ, 0, 2, 3));
    vec(bsy,  ex(C_FRZ,  S_FRZ, 0, 2, 3));
    vec(bsy,  ex(C_FRZ,  S_FRZ, 0, 2, 3));
    vec(bsy,  ex(C_FRZ,  S_HLT, 1, 2, 3));
    vec(brn,  ex(C_FRZ,  S_HLT, 1, 2, 3));
    vec(lu,   ex(C_FRZ,  S_HLT, 1, 2, 3));
    vec(rsti, ex(C_RST,  S_HLT, 1, 2, 3));
    vec(idle, ex(C_NORM, S_RUN, 0, 0, 0));
    // busy gap clears the timer: 3 + 3 busy cycles never halt
    vec(bsy,  ex(C_FRZ,  S_RUN, 0, 0, 0));
    vec(bsy,  ex(C_FRZ,  S_FRZ, 0, 0, 0));
    vec(bsy,  ex(C_FRZ,  S_FRZ, 0, 0, 0));
    vec(idle, ex(C_NORM, S_FRZ, 0, 0, 0));
    vec(bsy,  ex(C_FRZ,  S_RUN, 0, 0, 0));
    vec(bsy,  ex(C_FRZ,  S_FRZ, 0, 0, 0));
    vec(bsy,  ex(C_FRZ,  S_FRZ, 0, 0, 0));
    vec(idle, ex(C_NORM, S_FRZ, 0, 0, 0));
    // reset mid-freeze clears counters
    vec(brn,  ex(C_BR,   S_RUN, 0, 0, 0));
    vec(bsy,  ex(C_FRZ,  S_RUN, 0, 0, 1));
    vec(bsyrst, ex(C_RST, S_FRZ, 0, 0, 1));
    vec(idle, ex(C_NORM, S_RUN, 0, 0, 0));
    // saturation: 0x10000 load-use stalls
    for (int k = 0; k < 65536; k++) drive(lu);
    vec(idle, ex(C_NORM, S_RUN, 0, 16'hFFFF, 0));
    vec(lu,   ex(C_STL,  S_RUN, 0, 16'hFFFF, 0));
    vec(idle, ex(C_NORM, S_RUN, 0, 16'hFFFF, 0));

    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
